seg_scan_decoder: RTL and testbench

//   Receive-side monitor for the multiplexed 7-segment display bus (anodes + CA..CG, all active-low).

---
 rtl/seg_scan_decoder.sv | 209 ++++++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
//   Receive-side monitor for a multiplexed, active-low 7-segment display bus.
//   The anode and segment lines are synchronised to clk. A pattern is captured once it has
//   held for STABLE_CYCLES samples. Each captured digit is decoded into a shadow frame.
//   When every digit has been seen, the shadow frame is published on digits/digit_valid.
//   Optional feature macro: SEG_DECODE_HEX_EN (also decodes the A..F segment shapes).
module seg_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 16,
    parameter int SCAN_TIMEOUT  = 200000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_DIGITS-1:0]   an_n,
    input  logic [6:0]              seg_n,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    frame_done,
    output logic                    err_pattern,
    output logic                    blank
);

    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int LOW_W  = $clog2(NUM_DIGITS + 1);
    localparam int STAB_W = $clog2(STABLE_CYCLES);
    localparam int IDLE_W = $clog2(SCAN_TIMEOUT);

    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [STAB_W-1:0] STAB_PRE = STAB_W'(STABLE_CYCLES - 2);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(SCAN_TIMEOUT - 1);

    // Returns {legal, value}; unknown shapes decode to 4'hF and are flagged illegal.
    function automatic logic [4:0] seg_decode(input logic [6:0] code);
        logic [4:0] r;
        case (code)
            7'b1000000: r = {1'b1, 4'h0};
            7'b1111001: r = {1'b1, 4'h1};
            7'b0100100: r = {1'b1, 4'h2};
            7'b0110000: r = {1'b1, 4'h3};
            7'b0011001: r = {1'b1, 4'h4};
            7'b0010010: r = {1'b1, 4'h5};
            7'b0000010: r = {1'b1, 4'h6};
            7'b1111000: r = {1'b1, 4'h7};
            7'b0000000: r = {1'b1, 4'h8};
            7'b0010000: r = {1'b1, 4'h9};
`ifdef SEG_DECODE_HEX_EN
            7'b0001000: r = {1'b1, 4'hA};
            7'b0000011: r = {1'b1, 4'hB};
            7'b1000110: r = {1'b1, 4'hC};
            7'b0100001: r = {1'b1, 4'hD};
            7'b0000110: r = {1'b1, 4'hE};
            7'b0001110: r = {1'b1, 4'hF};
`endif
            default:    r = {1'b0, 4'hF};
        endcase
        return r;
    endfunction

    // Synchroniser stages, previous sample and stability counter
    logic [NUM_DIGITS-1:0]   an_m_q, an_s_q, an_p_q;
    logic [6:0]              seg_m_q, seg_s_q, seg_p_q;
    logic [STAB_W-1:0]       stab_cnt_q, stab_cnt_d;

    // Frame assembly and output state
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0]   shadow_ok_q, shadow_ok_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   digit_valid_q, digit_valid_d;
    logic                    frame_done_q, frame_done_d;
    logic                    err_pattern_q, err_pattern_d;
    logic                    blank_q, blank_d;
    logic [IDLE_W-1:0]       idle_cnt_q, idle_cnt_d;

    // Capture classification
    logic                    same_s;
    logic                    capture_s;
    logic                    onehot_cap_s;
    logic                    multi_cap_s;
    logic [LOW_W-1:0]        low_cnt_s;
    logic [IDX_W-1:0]        hit_idx_s;
    logic [4:0]              dec_s;

    // Two-flop synchronisers plus the one-sample history used for the stability check
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            an_m_q  <= '1;
            an_s_q  <= '1;
            an_p_q  <= '1;
            seg_m_q <= 7'h7F;
            seg_s_q <= 7'h7F;
            seg_p_q <= 7'h7F;
        end else begin
            an_m_q  <= an_n;
            an_s_q  <= an_m_q;
            an_p_q  <= an_s_q;
            seg_m_q <= seg_n;
            seg_s_q <= seg_m_q;
            seg_p_q <= seg_s_q;
        end
    end

    // Stability counter: restart on any change, saturate at STABLE_CYCLES-1.
    // Capture is the single step from STABLE_CYCLES-2 to STABLE_CYCLES-1.
    always_comb begin
        same_s     = ({an_s_q, seg_s_q} == {an_p_q, seg_p_q});
        stab_cnt_d = stab_cnt_q;
        capture_s  = 1'b0;
        if (!same_s) begin
            stab_cnt_d = '0;
        end else if (stab_cnt_q != STAB_MAX) begin
            stab_cnt_d = stab_cnt_q + STAB_W'(1);
            capture_s  = (stab_cnt_q == STAB_PRE);
        end else begin
            stab_cnt_d = stab_cnt_q;
        end
    end

    // Count the low anodes and remember which one, to classify the capture
    always_comb begin
        low_cnt_s = '0;
        hit_idx_s = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an_s_q[i]) begin
                low_cnt_s = low_cnt_s + LOW_W'(1);
                hit_idx_s = IDX_W'(i);
            end else begin
                low_cnt_s = low_cnt_s;
            end
        end
        onehot_cap_s = capture_s && (low_cnt_s == LOW_W'(1));
        multi_cap_s  = capture_s && (low_cnt_s > LOW_W'(1));
        dec_s        = seg_decode(seg_s_q);
    end

    // Shadow frame update, frame publication, error pulse and scan-timeout tracking
    always_comb begin
        shadow_d      = shadow_q;
        shadow_ok_d   = shadow_ok_q;
        seen_d        = seen_q;
        digits_d      = digits_q;
        digit_valid_d = digit_valid_q;
        frame_done_d  = 1'b0;
        err_pattern_d = 1'b0;
        blank_d       = blank_q;
        idle_cnt_d    = idle_cnt_q;

        if (onehot_cap_s) begin
            // A capture always beats a coincident timeout.
            shadow_d[4*hit_idx_s +: 4] = dec_s[3:0];
            shadow_ok_d[hit_idx_s]     = dec_s[4];
            seen_d[hit_idx_s]          = 1'b1;
            err_pattern_d              = ~dec_s[4];
            idle_cnt_d                 = '0;
            blank_d                    = 1'b0;
        end else begin
            err_pattern_d = multi_cap_s;
            if (idle_cnt_q == IDLE_MAX) begin
                blank_d = 1'b1;
                seen_d  = '0;
            end else begin
                idle_cnt_d = idle_cnt_q + IDLE_W'(1);
            end
        end

        if (&seen_d) begin
            digits_d      = shadow_d;
            digit_valid_d = shadow_ok_d;
            frame_done_d  = 1'b1;
            seen_d        = '0;
        end else begin
            frame_done_d  = 1'b0;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stab_cnt_q    <= '0;
            shadow_q      <= '0;
            shadow_ok_q   <= '0;
            seen_q        <= '0;
            digits_q      <= '0;
            digit_valid_q <= '0;
            frame_done_q  <= 1'b0;
            err_pattern_q <= 1'b0;
            blank_q       <= 1'b0;
            idle_cnt_q    <= '0;
        end else begin
            stab_cnt_q    <= stab_cnt_d;
            shadow_q      <= shadow_d;
            shadow_ok_q   <= shadow_ok_d;
            seen_q        <= seen_d;
            digits_q      <= digits_d;
            digit_valid_q <= digit_valid_d;
            frame_done_q  <= frame_done_d;
            err_pattern_q <= err_pattern_d;
            blank_q       <= blank_d;
            idle_cnt_q    <= idle_cnt_d;
        end
    end

    assign digits      = digits_q;
    assign digit_valid = digit_valid_q;
    assign frame_done  = frame_done_q;
    assign err_pattern = err_pattern_q;
    assign blank       = blank_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed testbench for seg_scan_decoder (timeout shortened to keep the run small).
module tb_seg_scan_decoder;

    localparam int ND = 4;
    localparam int SC = 16;
    localparam int TO = 2000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  an_n = 4'hF;
    logic [6:0]  seg_n = 7'h7F;
    logic [15:0] digits;
    logic [3:0]  digit_valid;
    logic        frame_done;
    logic        err_pattern;
    logic        blank;

    int errors = 0;
    int checks = 0;
    int fd_cnt = 0;
    int ep_cnt = 0;
    int fd0, ep0;

    seg_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC), .SCAN_TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .an_n(an_n), .seg_n(seg_n),
        .digits(digits), .digit_valid(digit_valid), .frame_done(frame_done),
        .err_pattern(err_pattern), .blank(blank)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled on the falling edge
    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_cnt++;
        if (err_pattern === 1'b1) ep_cnt++;
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    function automatic logic [6:0] seg_of(input int v);
        case (v)
            0:  return 7'b1000000;
            1:  return 7'b1111001;
            2:  return 7'b0100100;
            3:  return 7'b0110000;
            4:  return 7'b0011001;
            5:  return 7'b0010010;
            6:  return 7'b0000010;
            7:  return 7'b1111000;
            8:  return 7'b0000000;
            9:  return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic show(input logic [3:0] an, input logic [6:0] seg, input int n);
        an_n  = an;
        seg_n = seg;
        wait_cyc(n);
    endtask

    task automatic digit(input int idx, input logic [6:0] seg);
        logic [3:0] a;
        a = 4'b0001 << idx;
        show(~a, seg, 60);
        show(4'hF, 7'h7F, 20);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        wait_cyc(3);
        checks++; if (digits !== 16'h0000) begin errors++; $display("FAIL reset_digits: got %h want %h", digits, 16'h0000); end
        checks++; if (digit_valid !== 4'h0) begin errors++; $display("FAIL reset_valid: got %b want %b", digit_valid, 4'h0); end
        checks++; if ({frame_done, err_pattern, blank} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want %b", {frame_done, err_pattern, blank}, 3'b000); end
        reset_n = 1'b1;
        wait_cyc(30);
        checks++; if ({fd_cnt, ep_cnt} !== {32'd0, 32'd0}) begin errors++; $display("FAIL idle_after_reset: got fd=%0d ep=%0d want 0 0", fd_cnt, ep_cnt); end
        checks++; if (blank !== 1'b0) begin errors++; $display("FAIL idle_blank: got %b want 0", blank); end
    endtask

    task automatic test_scan();
        fd0 = fd_cnt; ep0 = ep_cnt;
        digit(3, seg_of(1));
        digit(2, seg_of(2));
        digit(1, seg_of(3));
        checks++; if (fd_cnt - fd0 !== 0) begin errors++; $display("FAIL scan_early_frame: got %0d want 0", fd_cnt - fd0); end
        digit(0, seg_of(4));
        checks++; if (fd_cnt - fd0 !== 1) begin errors++; $display("FAIL scan_frame_done: got %0d want 1", fd_cnt - fd0); end
        checks++; if (digits !== 16'h1234) begin errors++; $display("FAIL scan_digits: got %h want %h", digits, 16'h1234); end
        checks++; if (digit_valid !== 4'hF) begin errors++; $display("FAIL scan_valid: got %b want %b", digit_valid, 4'hF); end
        checks++; if (ep_cnt - ep0 !== 0) begin errors++; $display("FAIL scan_err: got %0d want 0", ep_cnt - ep0); end
    endtask

    task automatic test_illegal_digit();
        fd0 = fd_cnt; ep0 = ep_cnt;
        digit(3, seg_of(1));
        digit(2, 7'b1111111);
        digit(1, seg_of(3));
        digit(0, seg_of(4));
        checks++; if (digits !== 16'h1F34) begin errors++; $display("FAIL illegal_digits: got %h want %h", digits, 16'h1F34); end
        checks++; if (digit_valid !== 4'b1011) begin errors++; $display("FAIL illegal_valid: got %b want %b", digit_valid, 4'b1011); end
        checks++; if (ep_cnt - ep0 !== 1) begin errors++; $display("FAIL illegal_err_count: got %0d want 1", ep_cnt - ep0); end
        checks++; if (fd_cnt - fd0 !== 1) begin errors++; $display("FAIL illegal_frame: got %0d want 1", fd_cnt - fd0); end
    endtask

    task automatic test_glitch();
        fd0 = fd_cnt; ep0 = ep_cnt;
        digit(3, seg_of(5));
        digit(2, seg_of(6));
        show(4'b1101, seg_of(7), 40);
        show(4'b1101, 7'b1111111, 1);
        show(4'b1101, seg_of(7), 40);
        show(4'hF, 7'h7F, 20);
        digit(0, seg_of(8));
        checks++; if (digits !== 16'h5678) begin errors++; $display("FAIL glitch_digits: got %h want %h", digits, 16'h5678); end
        checks++; if (digit_valid !== 4'hF) begin errors++; $display("FAIL glitch_valid: got %b want %b", digit_valid, 4'hF); end
        checks++; if (ep_cnt - ep0 !== 0) begin errors++; $display("FAIL glitch_err: got %0d want 0", ep_cnt - ep0); end
        checks++; if (fd_cnt - fd0 !== 1) begin errors++; $display("FAIL glitch_frame: got %0d want 1", fd_cnt - fd0); end
    endtask

    task automatic test_multi_anode();
        fd0 = fd_cnt; ep0 = ep_cnt;
        digit(3, seg_of(9));
        digit(2, seg_of(0));
        show(4'b0011, seg_of(1), 50);
        show(4'hF, 7'h7F, 20);
        checks++; if (ep_cnt - ep0 !== 1) begin errors++; $display("FAIL multi_err: got %0d want 1", ep_cnt - ep0); end
        checks++; if (fd_cnt - fd0 !== 0) begin errors++; $display("FAIL multi_frame: got %0d want 0", fd_cnt - fd0); end
        digit(1, seg_of(2));
        checks++; if (fd_cnt - fd0 !== 0) begin errors++; $display("FAIL multi_seen_touched: got %0d want 0", fd_cnt - fd0); end
        digit(0, seg_of(1));
        checks++; if (fd_cnt - fd0 !== 1) begin errors++; $display("FAIL multi_resume_frame: got %0d want 1", fd_cnt - fd0); end
        checks++; if (digits !== 16'h9021) begin errors++; $display("FAIL multi_digits: got %h want %h", digits, 16'h9021); end
    endtask

    task automatic test_timeout();
        fd0 = fd_cnt;
        digit(1, seg_of(9));
        digit(0, seg_of(0));
        wait_cyc(TO / 2);
        checks++; if (blank !== 1'b0) begin errors++; $display("FAIL timeout_early_blank: got %b want 0", blank); end
        wait_cyc(TO);
        checks++; if (blank !== 1'b1) begin errors++; $display("FAIL timeout_blank: got %b want 1", blank); end
        checks++; if (digits !== 16'h9021) begin errors++; $display("FAIL timeout_digits_hold: got %h want %h", digits, 16'h9021); end
        checks++; if (digit_valid !== 4'hF) begin errors++; $display("FAIL timeout_valid_hold: got %b want %b", digit_valid, 4'hF); end
        digit(3, seg_of(4));
        checks++; if (blank !== 1'b0) begin errors++; $display("FAIL resume_blank: got %b want 0", blank); end
        digit(2, seg_of(5));
        checks++; if (fd_cnt - fd0 !== 0) begin errors++; $display("FAIL resume_seen_cleared: got %0d want 0", fd_cnt - fd0); end
        digit(1, seg_of(6));
        digit(0, seg_of(7));
        checks++; if (fd_cnt - fd0 !== 1) begin errors++; $display("FAIL resume_frame: got %0d want 1", fd_cnt - fd0); end
        checks++; if (digits !== 16'h4567) begin errors++; $display("FAIL resume_digits: got %h want %h", digits, 16'h4567); end
    endtask

    task automatic test_hex();
        logic [15:0] exp_d;
        logic [3:0]  exp_v;
        int          exp_e;
`ifdef SEG_DECODE_HEX_EN
        exp_d = 16'h123A; exp_v = 4'hF;    exp_e = 0;
`else
        exp_d = 16'h123F; exp_v = 4'b1110; exp_e = 1;
`endif
        fd0 = fd_cnt; ep0 = ep_cnt;
        digit(3, seg_of(1));
        digit(2, seg_of(2));
        digit(1, seg_of(3));
        digit(0, 7'b0001000);
        checks++; if (digits !== exp_d) begin errors++; $display("FAIL hex_digits: got %h want %h", digits, exp_d); end
        checks++; if (digit_valid !== exp_v) begin errors++; $display("FAIL hex_valid: got %b want %b", digit_valid, exp_v); end
        checks++; if (ep_cnt - ep0 !== exp_e) begin errors++; $display("FAIL hex_err: got %0d want %0d", ep_cnt - ep0, exp_e); end
    endtask

    task automatic test_reset_mid();
        digit(3, seg_of(9));
        digit(2, seg_of(8));
        reset_n = 1'b0;
        #1;
        checks++; if (digits !== 16'h0000) begin errors++; $display("FAIL midreset_digits: got %h want %h", digits, 16'h0000); end
        checks++; if (digit_valid !== 4'h0) begin errors++; $display("FAIL midreset_valid: got %b want %b", digit_valid, 4'h0); end
        checks++; if ({frame_done, err_pattern, blank} !== 3'b000) begin errors++; $display("FAIL midreset_flags: got %b want %b", {frame_done, err_pattern, blank}, 3'b000); end
        wait_cyc(2);
        reset_n = 1'b1;
        wait_cyc(5);
        fd0 = fd_cnt;
        digit(1, seg_of(5));
        digit(0, seg_of(6));
        checks++; if (fd_cnt - fd0 !== 0) begin errors++; $display("FAIL midreset_partial_kept: got %0d want 0", fd_cnt - fd0); end
        digit(3, seg_of(7));
        digit(2, seg_of(8));
        checks++; if (fd_cnt - fd0 !== 1) begin errors++; $display("FAIL midreset_frame: got %0d want 1", fd_cnt - fd0); end
        checks++; if (digits !== 16'h7856) begin errors++; $display("FAIL midreset_new_digits: got %h want %h", digits, 16'h7856); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_illegal_digit();
        test_glitch();
        test_multi_anode();
        test_timeout();
        test_hex();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
